mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
Iterative multiply/divide unit sitting directly downstream of the register file's read ports: consumes readData1 (rs) and readData2 (rt) and produces the HI/LO result registers for MULT/MULTU/DIV/DIVU.
Runs one bit per cycle (shift-add multiply, restoring divide), with a start/busy/done handshake to the control FSM.
Also supports MTHI/MTLO direct writes; HI/LO are read by the writeback mux (MFHI/MFLO).

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
clock_in  in  1  clock; all state updates on rising edge
rst  in  1  reset rst, synchronous, active-high
start  in  1  begin operation; sampled only in IDLE
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
operandA  in  WIDTH  rs value (multiplicand / dividend)
operandB  in  WIDTH  rt value (multiplier / divisor)
hi_we  in  1  MTHI: write writeData to HI (IDLE only)
lo_we  in  1  MTLO: write writeData to LO (IDLE only)
writeData  in  WIDTH  data for MTHI/MTLO
busy  out  1  operation in progress
done  out  1  one-cycle pulse; HI/LO valid
div_by_zero  out  1  set with done if a divide had operandB==0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0. Any in-flight operation is aborted with no done pulse. Reset dominates all other inputs.
- States: IDLE, RUN, FIX.
- IDLE: if start=1 at edge N, latch op. Latch |operandA| and |operandB| (absolute values only for signed ops; otherwise raw). Record result signs. Load counter=WIDTH. Set busy=1. Go to RUN.
- RUN: edges N+1..N+WIDTH. Each edge performs one iteration and decrements the counter. On the edge where the counter reaches 0, go to FIX.
  - Multiply: 2*WIDTH-bit accumulator, add-and-shift per multiplier bit.
  - Divide: restoring step (shift remainder, trial subtract, set quotient bit).
- FIX: edge N+WIDTH+1 writes hi/lo, sets done=1, busy=0, and returns to IDLE. done falls on the next edge. Total latency is WIDTH+1 edges after start is sampled (33 for WIDTH=32).
- MULT: 2*WIDTH-bit product is negated if the operand signs differ. hi=upper half, lo=lower half.
- DIV:
  - Quotient truncates toward zero; negate it if the signs differ.
  - Remainder takes the sign of the dividend.
  - lo=quotient, hi=remainder.
  - 0x80000000 / -1 gives lo=0x80000000, hi=0 (modulo-2^WIDTH wrap, no trap).
- Divide by zero: full latency is still taken. Result is hi=operandA (original), lo=all-ones, and div_by_zero=1 in the done cycle. div_by_zero is cleared at the next accepted start or at reset.
- hi_we/lo_we: honoured only in IDLE (writing writeData); ignored while busy.
  - If start and hi_we/lo_we are both asserted in IDLE, the write happens and start is also accepted. The final result overwrites HI/LO at FIX.
- start while busy: ignored; no queueing.
- Operands are latched at start; operandA/B may change freely during RUN.
- hi/lo hold their values between operations; the previous result stays visible while busy.

Decomposition:
- Shared package mdu_pkg:
  - op encodings: MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV
  - state encodings: IDLE, RUN, FIX
  - WIDTH default
- One natural sub-module: div_step. It is combinational, one restoring-division iteration (remainder in, divisor, next bit → remainder out, quotient bit). It is instantiated once in the RUN datapath.
- Multiply iteration, sign correction and control stay in mult_div_unit.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → done pulse exactly 33 edges after start, hi=0xFFFFFFFE, lo=0x00000001, busy high for those 33 cycles.
- MULT -3 (0xFFFFFFFD) × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV -7 / 2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU 7 / 2 → lo=3, hi=1.
- DIVU 100 / 0 → hi=0x00000064, lo=0xFFFFFFFF, div_by_zero=1 with done. Then DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
- Handshake checks:
  - MTHI 0x1234 in IDLE → hi=0x1234 next edge.
  - start MULT 2×3, then pulse start and hi_we during RUN → both ignored; final result is hi=0, lo=6.
- Reset mid-operation: rst at the 10th RUN edge → busy=0, hi=lo=0, no done pulse. A new start afterwards completes normally with full latency.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, default width.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    // op[1] selects divide, op[0] selects signed
    localparam logic [1:0] MDU_MULTU = 2'b00;
    localparam logic [1:0] MDU_MULT  = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_DIV   = 2'b11;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] FIX  = 2'b10;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
// Purely combinational; no handshake.
import mdu_pkg::*;

module div_step #(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] divisor,
    input  logic             nextBit,
    output logic [WIDTH-1:0] remOut,
    output logic             qBit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // remIn < divisor keeps shifted below 2*divisor, so trial's top bit is a clean borrow flag
    always_comb begin
        shifted = {remIn, nextBit};
        trial   = shifted - {1'b0, divisor};
        qBit    = ~trial[WIDTH];
        remOut  = qBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit (shift-add multiply, restoring divide) with MTHI/MTLO writes.
// Latency WIDTH+1 edges from accepted start to done; start and HI/LO writes are ignored while busy.
import mdu_pkg::*;

module mult_div_unit #(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clock_in,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]         state;
    logic [CW-1:0]      counter;
    logic               isDiv;
    logic               negProd;
    logic               negRem;
    logic               divZero;
    logic [WIDTH-1:0]   origA;
    // multiplicand for multiply, divisor for divide
    logic [WIDTH-1:0]   opnd;
    // multiply: {partial product, remaining multiplier}; divide: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc;

    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    logic [WIDTH-1:0]   remNext;
    logic               qBit;
    logic [2*WIDTH-1:0] divNext;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotFix;
    logic [WIDTH-1:0]   remFix;

    div_step #(.WIDTH(WIDTH)) u_divStep (
        .remIn   (acc[2*WIDTH-1:WIDTH]),
        .divisor (opnd),
        .nextBit (acc[WIDTH-1]),
        .remOut  (remNext),
        .qBit    (qBit)
    );

    always_comb begin
        aNeg    = op[0] & operandA[WIDTH-1];
        bNeg    = op[0] & operandB[WIDTH-1];
        absA    = aNeg ? -operandA : operandA;
        absB    = bNeg ? -operandB : operandB;

        mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mulNext = {mulSum, acc[WIDTH-1:1]};
        divNext = {remNext, acc[WIDTH-2:0], qBit};

        prodFix = negProd ? -acc : acc;
        quotFix = negProd ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remFix  = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock_in) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= '0;
            isDiv       <= 1'b0;
            negProd     <= 1'b0;
            negRem      <= 1'b0;
            divZero     <= 1'b0;
            origA       <= '0;
            opnd        <= '0;
            acc         <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= writeData;
                    if (lo_we) lo <= writeData;
                    if (start) begin
                        isDiv       <= op[1];
                        negProd     <= aNeg ^ bNeg;
                        negRem      <= aNeg;
                        divZero     <= op[1] & (operandB == '0);
                        origA       <= operandA;
                        opnd        <= op[1] ? absB : absA;
                        acc         <= {{WIDTH{1'b0}}, op[1] ? absA : absB};
                        counter     <= CNT_LOAD;
                        div_by_zero <= 1'b0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    acc     <= isDiv ? divNext : mulNext;
                    counter <= counter - CNT_ONE;
                    if (counter == CNT_ONE) state <= FIX;
                end
                FIX: begin
                    if (!isDiv) begin
                        hi <= prodFix[2*WIDTH-1:WIDTH];
                        lo <= prodFix[WIDTH-1:0];
                    end else if (divZero) begin
                        hi <= origA;
                        lo <= '1;
                    end else begin
                        hi <= remFix;
                        lo <= quotFix;
                    end
                    div_by_zero <= divZero;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
